// File: rtl/dispatch_ctrl.sv
// dispatch_ctrl: fetch-to-decode instruction queue and issue sequencer.
// Ports: clk/rst/rdy/clear control, if_* fetch offer, dec_* head to decoder,
// *_full and dec_jalr_ready issue gates, stall_cnt perf counter.
module dispatch_ctrl #(
    parameter int QUEUE_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        clear,
    input  logic        if_valid,
    input  logic [31:0] if_pc,
    input  logic [31:0] if_ins,
    input  logic        if_jp,
    output logic        if_ready,
    output logic        dec_ok,
    output logic [31:0] dec_pc,
    output logic [31:0] dec_ins,
    output logic        dec_jp,
    input  logic        rob_full,
    input  logic        rs_full,
    input  logic        lsb_full,
    input  logic        dec_jalr_ready,
    output logic [31:0] stall_cnt
);
    localparam int AW = $clog2(QUEUE_DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL = CW'(QUEUE_DEPTH);
    localparam logic [AW-1:0] ONE = AW'(1);

    typedef enum logic [1:0] {IDLE, ISSUE, JWAIT} state_t;
    typedef enum logic [1:0] {C_ROB, C_RS, C_LSB, C_JALR} cls_t;

    state_t state;
    cls_t cls;

    logic [31:0] mem_pc [QUEUE_DEPTH];
    logic [31:0] mem_ins [QUEUE_DEPTH];
    logic        mem_jp [QUEUE_DEPTH];

    logic [AW-1:0] head;
    logic [AW-1:0] tail;
    logic [AW-1:0] head_n;
    logic [CW-1:0] count;
    logic [CW-1:0] count_n;
    logic [CW-1:0] rem;
    logic          can_issue;
    logic          enq;

    always_comb begin
        cls = C_ROB;
        case (dec_ins[6:0])
            7'b0000011, 7'b0100011:             cls = C_LSB;
            7'b1100011, 7'b0010011, 7'b0110011: cls = C_RS;
            7'b1100111:                         cls = C_JALR;
            default:                            cls = C_ROB;
        endcase
    end

    always_comb begin
        can_issue = !rob_full;
        case (cls)
            C_LSB:   can_issue = !rob_full && !lsb_full;
            C_RS:    can_issue = !rob_full && !rs_full;
            C_JALR:  can_issue = !rob_full && dec_jalr_ready;
            default: can_issue = !rob_full;
        endcase
    end

    assign if_ready = rdy && !rst && !clear && (count < FULL);
    assign enq = if_valid && if_ready;

    always_comb begin
        dec_ok = 1'b0;
        if (rdy && !rst && !clear && count != '0) begin
            case (state)
                ISSUE:   dec_ok = can_issue;
                JWAIT:   dec_ok = dec_jalr_ready && !rob_full;
                default: dec_ok = 1'b0;
            endcase
        end
    end

    assign count_n = count + CW'(enq) - CW'(dec_ok);
    // entries left behind the current head after this cycle's dequeue
    assign rem = count - CW'(dec_ok);
    assign head_n = head + (dec_ok ? ONE : '0);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            head      <= '0;
            tail      <= '0;
            count     <= '0;
            dec_pc    <= '0;
            dec_ins   <= '0;
            dec_jp    <= 1'b0;
            stall_cnt <= '0;
        end else if (rdy) begin
            if (clear) begin
                state <= IDLE;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (count != '0 && !dec_ok && stall_cnt != 32'hFFFF_FFFF)
                    stall_cnt <= stall_cnt + 32'd1;
                if (enq) begin
                    mem_pc[tail]  <= if_pc;
                    mem_ins[tail] <= if_ins;
                    mem_jp[tail]  <= if_jp;
                    tail          <= tail + ONE;
                end
                head  <= head_n;
                count <= count_n;
                // head registers track the entry that will sit at head_n;
                // when the queue drains to empty the arriving word becomes head
                if (rem != '0) begin
                    dec_pc  <= mem_pc[head_n];
                    dec_ins <= mem_ins[head_n];
                    dec_jp  <= mem_jp[head_n];
                end else if (enq) begin
                    dec_pc  <= if_pc;
                    dec_ins <= if_ins;
                    dec_jp  <= if_jp;
                end
                case (state)
                    IDLE: begin
                        if (enq)
                            state <= ISSUE;
                    end
                    ISSUE: begin
                        if (count_n == '0)
                            state <= IDLE;
                        else if (!dec_ok && cls == C_JALR && !dec_jalr_ready)
                            state <= JWAIT;
                    end
                    JWAIT: begin
                        if (dec_ok)
                            state <= (count_n == '0) ? IDLE : ISSUE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_dispatch_ctrl.sv
// tb_dispatch_ctrl: directed plus randomized checks of dispatch_ctrl
// against a queue-based reference model.
module tb_dispatch_ctrl;
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        jp;
    } ent_t;

    localparam logic [31:0] ADDI = 32'h00100093;
    localparam logic [31:0] JALR = 32'h000080E7;
    localparam logic [31:0] LW   = 32'h00002083;
    localparam logic [31:0] SW   = 32'h00112023;

    logic        clk = 1'b0;
    logic        rst, rdy, clear;
    logic        if_valid, if_jp;
    logic [31:0] if_pc, if_ins;
    logic        if_ready, dec_ok, dec_jp;
    logic [31:0] dec_pc, dec_ins, stall_cnt;
    logic        rob_full, rs_full, lsb_full, dec_jalr_ready;

    int     checks = 0;
    int     failures = 0;
    longint ms = 0;
    ent_t   q[$];
    logic [31:0] base;

    dispatch_ctrl #(.QUEUE_DEPTH(4)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .clear(clear),
        .if_valid(if_valid), .if_pc(if_pc), .if_ins(if_ins), .if_jp(if_jp),
        .if_ready(if_ready), .dec_ok(dec_ok), .dec_pc(dec_pc),
        .dec_ins(dec_ins), .dec_jp(dec_jp), .rob_full(rob_full),
        .rs_full(rs_full), .lsb_full(lsb_full),
        .dec_jalr_ready(dec_jalr_ready), .stall_cnt(stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // issue rule for a head instruction, straight from the opcode table
    function automatic logic can_go(input logic [31:0] ins);
        logic [6:0] op;
        op = ins[6:0];
        if (rob_full) return 1'b0;
        if (op == 7'h03 || op == 7'h23) return !lsb_full;
        if (op == 7'h63 || op == 7'h13 || op == 7'h33) return !rs_full;
        if (op == 7'h67) return dec_jalr_ready;
        return 1'b1;
    endfunction

    task automatic cyc();
        logic er, eo;
        ent_t e;
        #1;
        er = rdy && !rst && !clear && (q.size() < 4);
        eo = rdy && !rst && !clear && (q.size() > 0) && can_go(q[0].ins);
        chk("if_ready", {31'b0, if_ready}, {31'b0, er});
        chk("dec_ok", {31'b0, dec_ok}, {31'b0, eo});
        if (q.size() > 0) begin
            chk("dec_pc", dec_pc, q[0].pc);
            chk("dec_ins", dec_ins, q[0].ins);
            chk("dec_jp", {31'b0, dec_jp}, {31'b0, q[0].jp});
        end
        chk("stall_cnt", stall_cnt, ms[31:0]);
        if (rst) begin
            q.delete();
            ms = 0;
        end else if (rdy) begin
            if (clear) begin
                q.delete();
            end else begin
                if (q.size() > 0 && !eo && ms < 64'hFFFF_FFFF) ms++;
                if (eo) void'(q.pop_front());
                if (if_valid && er) begin
                    e.pc = if_pc;
                    e.ins = if_ins;
                    e.jp = if_jp;
                    q.push_back(e);
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic offer(input logic [31:0] pc, input logic [31:0] ins);
        if_valid = 1'b1;
        if_pc = pc;
        if_ins = ins;
        cyc();
        if_valid = 1'b0;
    endtask

    function automatic logic [31:0] rnd_ins();
        logic [6:0] ops [10];
        logic [31:0] r;
        ops = '{7'h03, 7'h23, 7'h63, 7'h13, 7'h33,
                7'h37, 7'h17, 7'h6F, 7'h67, 7'h7F};
        r = $urandom;
        return {r[31:7], ops[$urandom_range(0, 9)]};
    endfunction

    initial begin
        rst = 1'b1; rdy = 1'b1; clear = 1'b0;
        if_valid = 1'b0; if_pc = '0; if_ins = '0; if_jp = 1'b0;
        rob_full = 1'b0; rs_full = 1'b0; lsb_full = 1'b0;
        dec_jalr_ready = 1'b0;
        @(negedge clk);
        cyc();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst_pc", dec_pc, 32'h0);
        chk("rst_ins", dec_ins, 32'h0);
        chk("rst_jp", {31'b0, dec_jp}, 32'h0);
        chk("rst_stall", stall_cnt, 32'h0);

        // single ADDI
        offer(32'h0, ADDI);
        #1;
        chk("t1_ok", {31'b0, dec_ok}, 32'h1);
        chk("t1_pc", dec_pc, 32'h0);
        cyc();
        #1;
        chk("t1_stall", stall_cnt, 32'h0);

        // fill while RS is full, fifth offer refused
        rs_full = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if_valid = 1'b1;
            if_pc = 32'(i * 4);
            if_ins = ADDI;
            if (i == 4) begin
                #1;
                chk("t2_full", {31'b0, if_ready}, 32'h0);
            end
            cyc();
        end
        if_valid = 1'b0;
        rs_full = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("t2_ok", {31'b0, dec_ok}, 32'h1);
            chk("t2_pc", dec_pc, 32'(i * 4));
            cyc();
        end

        // JALR waits on rs1
        base = ms[31:0];
        offer(32'h100, JALR);
        repeat (3) cyc();
        dec_jalr_ready = 1'b1;
        #1;
        chk("t3_stall", stall_cnt, base + 32'd3);
        chk("t3_ok", {31'b0, dec_ok}, 32'h1);
        cyc();
        dec_jalr_ready = 1'b0;

        // blocked LW keeps SW behind it
        lsb_full = 1'b1;
        offer(32'h200, LW);
        offer(32'h204, SW);
        repeat (2) begin
            #1;
            chk("t4_pc", dec_pc, 32'h200);
            chk("t4_ok", {31'b0, dec_ok}, 32'h0);
            cyc();
        end
        lsb_full = 1'b0;
        repeat (2) cyc();

        // clear with an offer in flight
        rs_full = 1'b1;
        offer(32'h300, ADDI);
        offer(32'h304, ADDI);
        offer(32'h308, ADDI);
        clear = 1'b1;
        if_valid = 1'b1;
        if_pc = 32'h30C;
        if_ins = ADDI;
        base = ms[31:0];
        #1;
        chk("t5_rdy", {31'b0, if_ready}, 32'h0);
        chk("t5_ok", {31'b0, dec_ok}, 32'h0);
        cyc();
        clear = 1'b0;
        if_valid = 1'b0;
        rs_full = 1'b0;
        #1;
        chk("t5_ok2", {31'b0, dec_ok}, 32'h0);
        chk("t5_stall", stall_cnt, base);
        cyc();
        offer(32'h400, ADDI);
        #1;
        chk("t5_pc", dec_pc, 32'h400);
        cyc();

        // rdy low freezes everything
        rs_full = 1'b1;
        offer(32'h500, ADDI);
        offer(32'h504, ADDI);
        rs_full = 1'b0;
        rdy = 1'b0;
        base = ms[31:0];
        repeat (2) begin
            #1;
            chk("t6_ok", {31'b0, dec_ok}, 32'h0);
            chk("t6_pc", dec_pc, 32'h500);
            chk("t6_stall", stall_cnt, base);
            cyc();
        end
        rdy = 1'b1;
        #1;
        chk("t6_ok2", {31'b0, dec_ok}, 32'h1);
        chk("t6_pc2", dec_pc, 32'h500);
        cyc();
        cyc();

        // randomized traffic
        repeat (500) begin
            rst = ($urandom_range(0, 63) == 0);
            clear = ($urandom_range(0, 19) == 0);
            rdy = ($urandom_range(0, 7) != 0);
            rob_full = ($urandom_range(0, 5) == 0);
            rs_full = ($urandom_range(0, 3) == 0);
            lsb_full = ($urandom_range(0, 3) == 0);
            dec_jalr_ready = ($urandom_range(0, 1) == 1);
            if_valid = ($urandom_range(0, 3) != 0);
            if_pc = $urandom;
            if_ins = rnd_ins();
            if_jp = ($urandom_range(0, 1) == 1);
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
